// File: rtl/rom_access_arbiter_if.sv
// rtl/rom_access_arbiter_if.sv - read ports and ROM-controller bus of the boot ROM arbiter
// slave: arbiter view; master: core/ROM-controller view.
interface rom_access_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic              p0_req;
  logic [ADDR_W-1:0] p0_addr;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;
  logic              p1_req;
  logic [ADDR_W-1:0] p1_addr;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;
  logic              rom_req;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_rdata;
  logic              rom_ready;

  modport slave (
    input  p0_req, p0_addr, p1_req, p1_addr, rom_rdata, rom_ready,
    output p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata, rom_req, rom_addr
  );

  modport master (
    output p0_req, p0_addr, p1_req, p1_addr, rom_rdata, rom_ready,
    input  p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata, rom_req, rom_addr
  );
endinterface

// File: rtl/rom_access_arbiter.sv
// rtl/rom_access_arbiter.sv - two-port boot ROM arbiter with MBIST entry/exit sequencing
// Optional ROM_ARB_ADDR_CHECK_EN: misaligned/out-of-range reads answered locally with 32'hDEAD_BEEF.
module rom_access_arbiter #(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 32,
  parameter int MAX_WAIT  = 4,
  parameter int ROM_BYTES = 32768
) (
  input  logic clk,
  input  logic rst,
  rom_access_arbiter_if.slave bus,
  input  logic mbist_req,
  output logic rom_mbist_en,
  input  logic rom_mbist_done,
  input  logic rom_mbist_fail,
  output logic mbist_done,
  output logic mbist_fail,
  output logic arb_idle,
  output logic rsp_err
);
  localparam int WCNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {S_NORMAL, S_DRAIN, S_MBIST} state_t;

  state_t            state, state_nxt;
  logic              grant_en;
  logic              p1_win;
  logic              any_gnt;
  logic [ADDR_W-1:0] win_addr;
  logic [WCNT_W-1:0] wait_cnt;
  logic              pend_valid;
  logic              pend_owner;
  logic              rsp_hit;
  logic [DATA_W-1:0] rsp_data;
  logic              fwd_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_NORMAL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_NORMAL: if (mbist_req)   state_nxt = S_DRAIN;
      S_DRAIN:  if (!pend_valid) state_nxt = S_MBIST;
      S_MBIST:  if (!mbist_req)  state_nxt = S_NORMAL;
      default:                   state_nxt = S_NORMAL;
    endcase
  end

  always_comb begin
    grant_en     = (state == S_NORMAL) && !mbist_req;
    rom_mbist_en = (state == S_MBIST);
  end

  // p0 has priority unless p1 has been starved for MAX_WAIT cycles.
  assign p1_win     = bus.p1_req && (!bus.p0_req || (wait_cnt == WAIT_MAX));
  assign bus.p0_gnt = grant_en && bus.p0_req && !p1_win;
  assign bus.p1_gnt = grant_en && p1_win;
  assign any_gnt    = bus.p0_gnt || bus.p1_gnt;
  assign win_addr   = bus.p1_gnt ? bus.p1_addr : bus.p0_addr;

`ifdef ROM_ARB_ADDR_CHECK_EN
  localparam logic [ADDR_W:0] ROM_LIMIT = (ADDR_W+1)'(ROM_BYTES);
  logic addr_bad;
  logic pend_bad;
  assign addr_bad = (win_addr[1:0] != 2'b00) || ({1'b0, win_addr} >= ROM_LIMIT);
  assign fwd_ok   = !addr_bad;
  assign rsp_hit  = pend_valid && (pend_bad || bus.rom_ready);
  assign rsp_data = pend_bad ? DATA_W'(32'hDEAD_BEEF) : bus.rom_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_bad <= 1'b0;
    else     pend_bad <= any_gnt && addr_bad;
  end
`else
  assign fwd_ok   = 1'b1;
  assign rsp_hit  = pend_valid && bus.rom_ready;
  assign rsp_data = bus.rom_rdata;
`endif

  assign bus.rom_req  = any_gnt && fwd_ok;
  assign bus.rom_addr = win_addr;

  assign bus.p0_rvalid = rsp_hit && !pend_owner;
  assign bus.p1_rvalid = rsp_hit && pend_owner;
  assign bus.p0_rdata  = bus.p0_rvalid ? rsp_data : '0;
  assign bus.p1_rdata  = bus.p1_rvalid ? rsp_data : '0;
  assign arb_idle      = !any_gnt && !pend_valid;

  // Pending lives exactly one cycle: the ROM answers next cycle or never.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_owner <= 1'b0;
      rsp_err    <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      pend_valid <= any_gnt;
      pend_owner <= bus.p1_gnt;
      if (pend_valid && !rsp_hit) rsp_err <= 1'b1;
      if (bus.p1_gnt || !bus.p1_req)  wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX)  wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mbist_done <= 1'b0;
      mbist_fail <= 1'b0;
    end else if (state == S_DRAIN && state_nxt == S_MBIST) begin
      mbist_done <= 1'b0;
      mbist_fail <= 1'b0;
    end else if (state == S_MBIST) begin
      mbist_done <= rom_mbist_done;
      mbist_fail <= rom_mbist_fail;
    end
  end
endmodule
